// File: rtl/mult_share_ctrl.sv
`timescale 1ns/1ps
// Front-end for one shared combinational signed multiplier. Two requesters are served
// round-robin; operands are registered, held for SETTLE_CYC cycles, then the product is captured and returned.
module mult_share_ctrl #(
    parameter int unsigned N          = 5,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [N-1:0]     req0_x,
    input  logic [N-1:0]     req0_y,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [N-1:0]     req1_x,
    input  logic [N-1:0]     req1_y,
    output logic             req1_ready,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [2*N-1:0]   resp_p,
    output logic [N-1:0]     mul_x,
    output logic [N-1:0]     mul_y,
    input  logic [2*N-1:0]   mul_p,
    output logic             busy
);
    localparam int unsigned CntW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RESP
    } stateE;

    stateE           state;
    stateE           stateNext;
    logic [CntW-1:0] cnt;
    logic            owner;
    logic            last;
    logic            grant;
    logic            accept;
    logic            respDone;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Arbitration, next state and the combinational accept strobes
    always_comb begin
        stateNext  = state;
        grant      = 1'b0;
        accept     = 1'b0;
        respDone   = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;

        // On a tie the requester that was not served last wins
        if (req0_valid && req1_valid) begin
            grant = ~last;
        end else begin
            grant = req1_valid;
        end

        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    accept     = 1'b1;
                    req0_ready = ~grant;
                    req1_ready = grant;
                    stateNext  = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    stateNext = RESP;
                end
            end
            RESP: begin
                respDone = owner ? resp1_ready : resp0_ready;
                if (respDone) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Operand, product, arbitration pointer and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_x       <= '0;
            mul_y       <= '0;
            resp_p      <= '0;
            owner       <= 1'b0;
            last        <= 1'b1;
            cnt         <= '0;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            busy <= (stateNext != IDLE);
            // owner only changes on accept, when the next state is never RESP
            resp0_valid <= (stateNext == RESP) && !owner;
            resp1_valid <= (stateNext == RESP) && owner;

            if (accept) begin
                mul_x <= grant ? req1_x : req0_x;
                mul_y <= grant ? req1_y : req0_y;
                owner <= grant;
                cnt   <= CntW'(SETTLE_CYC - 1);
            end

            if (state == SETTLE) begin
                if (cnt != '0) begin
                    cnt <= cnt - CntW'(1);
                end else begin
                    resp_p <= mul_p;
                end
            end

            if (respDone) begin
                last <= owner;
            end
        end
    end

endmodule
